// File: rtl/brick_game_ctrl_if.sv
// Bus between the game controller and the external ball/brick collision datapath.
// The controller publishes the current game state and takes the datapath's next-state result.
interface brick_game_ctrl_if;
    logic [1439:0] bricks;
    logic [9:0]    ball_x;
    logic [9:0]    ball_y;
    logic [9:0]    ball_vx;
    logic [9:0]    ball_vy;
    logic [1:0]    ball_dir;
    logic [1439:0] next_bricks;
    logic [9:0]    next_ball_x;
    logic [9:0]    next_ball_y;
    logic [9:0]    next_ball_vx;
    logic [9:0]    next_ball_vy;
    logic [1:0]    next_ball_dir;
    logic          collision_trig;

    modport master (
        output bricks, ball_x, ball_y, ball_vx, ball_vy, ball_dir,
        input  next_bricks, next_ball_x, next_ball_y, next_ball_vx, next_ball_vy,
        input  next_ball_dir, collision_trig
    );

    modport slave (
        input  bricks, ball_x, ball_y, ball_vx, ball_vy, ball_dir,
        output next_bricks, next_ball_x, next_ball_y, next_ball_vx, next_ball_vy,
        output next_ball_dir, collision_trig
    );
endinterface

// File: rtl/brick_game_ctrl.sv
// Brick game controller: physics tick, game-state registers and serve/play/miss/win/over FSM.
// Optional BRICK_GAME_SPEEDUP_EN adds a ball speed-up every 16 scoring ticks.
module brick_game_ctrl #(
    parameter int unsigned TICK_DIV   = 833334,
    parameter int unsigned LIVES0     = 3,
    parameter int unsigned BRICK_ROWS = 6,
    parameter int unsigned VX0        = 2,
    parameter int unsigned VY0        = 2,
    parameter int unsigned VMAX       = 6,
    parameter int unsigned MISS_HOLD  = 30
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_launch_i,
    input  logic [9:0]                board_x_i,
    brick_game_ctrl_if.master         dp,
    output logic [2:0]                game_state_o,
    output logic [1:0]                lives_o,
    output logic [15:0]               score_o,
    output logic                      sfx_hit_o
);

    localparam int unsigned CntW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MissW = (MISS_HOLD > 1) ? $clog2(MISS_HOLD + 1) : 1;

    function automatic logic [1439:0] bricks_init();
        logic [1439:0] b;
        b = '0;
        for (int unsigned r = 0; r < 24; r++) begin
            if (r < BRICK_ROWS) begin
                for (int unsigned c = 0; c < 20; c++) begin
                    b[3*(c+20*r) +: 3] = 3'd1;
                end
            end
        end
        return b;
    endfunction

    localparam logic [1439:0] BricksInit = bricks_init();

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPlay = 3'd1,
        StMiss = 3'd2,
        StWin  = 3'd3,
        StOver = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [MissW-1:0]    miss_q, miss_d;
    logic [1439:0]       bricks_q, bricks_d;
    logic [9:0]          bx_q, bx_d, by_q, by_d, vx_q, vx_d, vy_q, vy_d;
    logic [1:0]          dir_q, dir_d;
    logic [1:0]          lives_q, lives_d;
    logic [15:0]         score_q, score_d;
    logic                sfx_q, sfx_d;
    logic                tick;
    logic                scoring;
    logic [9:0]          serve_x;

    assign tick    = (cnt_q == CntW'(TICK_DIV - 1));
    assign cnt_d   = tick ? '0 : cnt_q + 1'b1;
    assign serve_x = board_x_i + 10'd40;
    assign scoring = (dp.next_bricks != bricks_q);

`ifdef BRICK_GAME_SPEEDUP_EN
    logic [3:0] hit_q, hit_d;

    function automatic logic [9:0] bump(input logic [9:0] v);
        return (v >= 10'(VMAX)) ? 10'(VMAX) : v + 10'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hit_q <= '0;
        else        hit_q <= hit_d;
    end
`endif

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        bricks_d = bricks_q;
        bx_d     = bx_q;
        by_d     = by_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        dir_d    = dir_q;
        lives_d  = lives_q;
        score_d  = score_q;
        sfx_d    = 1'b0;
`ifdef BRICK_GAME_SPEEDUP_EN
        hit_d    = hit_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Track the paddle so the serve starts from wherever it is at launch.
                bx_d  = serve_x;
                by_d  = 10'd457;
                dir_d = 2'b10;
                vx_d  = 10'(VX0);
                vy_d  = 10'(VY0);
`ifdef BRICK_GAME_SPEEDUP_EN
                hit_d = '0;
`endif
                if (btn_launch_i) state_d = StPlay;
            end
            StPlay: begin
                if (tick) begin
                    bricks_d = dp.next_bricks;
                    bx_d     = dp.next_ball_x;
                    by_d     = dp.next_ball_y;
                    vx_d     = dp.next_ball_vx;
                    vy_d     = dp.next_ball_vy;
                    dir_d    = dp.next_ball_dir;
                    sfx_d    = dp.collision_trig;
                    if (scoring) begin
                        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
`ifdef BRICK_GAME_SPEEDUP_EN
                        hit_d = hit_q + 4'd1;
                        if (hit_q == 4'd15) begin
                            vx_d = bump(dp.next_ball_vx);
                            vy_d = bump(dp.next_ball_vy);
                        end
`endif
                    end
                    // Clearing the last brick wins even if the ball is lost on the same tick.
                    if (dp.next_bricks == '0) begin
                        state_d = StWin;
                    end else if (dp.next_ball_y >= 10'd470 && dp.next_ball_dir[0]) begin
                        state_d = StMiss;
                        miss_d  = '0;
                    end
                end
            end
            StMiss: begin
                if (tick) begin
                    if (miss_q == MissW'(MISS_HOLD - 1)) begin
                        lives_d = lives_q - 2'd1;
                        state_d = (lives_q == 2'd1) ? StOver : StIdle;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
            end
            StWin, StOver: begin
                if (btn_launch_i) begin
                    bricks_d = BricksInit;
                    lives_d  = 2'(LIVES0);
                    score_d  = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            miss_q   <= '0;
            bricks_q <= BricksInit;
            bx_q     <= '0;
            by_q     <= 10'd457;
            vx_q     <= 10'(VX0);
            vy_q     <= 10'(VY0);
            dir_q    <= 2'b10;
            lives_q  <= 2'(LIVES0);
            score_q  <= '0;
            sfx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
            bricks_q <= bricks_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            dir_q    <= dir_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            sfx_q    <= sfx_d;
        end
    end

    // In IDLE the ball sits on the paddle combinationally, which also covers the reset value.
    always_comb begin
        dp.bricks = bricks_q;
        if (state_q == StIdle) begin
            dp.ball_x   = serve_x;
            dp.ball_y   = 10'd457;
            dp.ball_vx  = 10'(VX0);
            dp.ball_vy  = 10'(VY0);
            dp.ball_dir = 2'b10;
        end else begin
            dp.ball_x   = bx_q;
            dp.ball_y   = by_q;
            dp.ball_vx  = vx_q;
            dp.ball_vy  = vy_q;
            dp.ball_dir = dir_q;
        end
    end

    assign game_state_o = state_q;
    assign lives_o      = lives_q;
    assign score_o      = score_q;
    assign sfx_hit_o    = sfx_q;

endmodule

// File: doc/brick_game_ctrl.md
Name: brick_game_ctrl

Overview:
- Sequences the combinational ball/brick collision datapath, which is instantiated outside this block.
- Owns the game-state registers: bricks, ball position, velocity, direction, lives and score.
- Generates the physics update tick and runs the serve/play/miss/win/game-over state machine.
- Sits between the paddle/button inputs and the VGA renderer.

Parameters:
- TICK_DIV, 833334: clk cycles per physics tick (60 Hz at 50 MHz).
- LIVES0, 3: lives at game start (1..3).
- BRICK_ROWS, 6: brick rows filled at game start (0..24).
- VX0, 2: serve x speed.
- VY0, 2: serve y speed.
- VMAX, 6: speed cap for the optional speed-up.
- MISS_HOLD, 30: ticks spent in MISS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_launch  in  1  debounced single-cycle launch/restart pulse
- board_x  in  10  paddle left x
- bricks  out  1440  brick grid: 480 slots of 3 bits, 20 cols x 24 rows, slot index = col + 20*row
- ball_x  out  10  ball left x
- ball_y  out  10  ball top y
- ball_vx  out  10  ball x speed
- ball_vy  out  10  ball y speed
- ball_dir  out  2  bit1 = 1 means moving right; bit0 = 1 means moving down
- next_bricks  in  1440  datapath result
- next_ball_x  in  10  datapath result
- next_ball_y  in  10  datapath result
- next_ball_vx  in  10  datapath result
- next_ball_vy  in  10  datapath result
- next_ball_dir  in  2  datapath result
- collision_trig  in  1  datapath collision flag
- game_state  out  3  current state encoding
- lives  out  2  remaining lives
- score  out  16  bricks-cleared tick count
- sfx_hit  out  1  one-cycle pulse on a collision

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, tick counter=0
  - bricks = each slot in rows 0..BRICK_ROWS-1 is 3'd1, all other slots 0
  - lives=LIVES0, score=0, ball_dir=2'b10, ball_vx=VX0, ball_vy=VY0
  - ball_x=board_x+40, ball_y=457, sfx_hit=0
- Tick generator:
  - Counter runs 0..TICK_DIV-1 in all states and wraps to 0.
  - tick=1 in the cycle where counter==TICK_DIV-1.
- State encoding: IDLE=0, PLAY=1, MISS=2, WIN=3, OVER=4.
- IDLE:
  - Every cycle: ball_x=board_x+40, ball_y=457, ball_dir=2'b10, vx=VX0, vy=VY0.
  - btn_launch=1 -> PLAY on the next edge.
- PLAY:
  - On tick, all ball registers and bricks load their next_* inputs in the same edge (datapath is zero-latency).
  - If next_bricks != bricks: score+1, saturating at 16'hFFFF.
  - If collision_trig: sfx_hit=1 for exactly that one cycle.
  - Checks on that tick, in priority order:
    - next_bricks all zero -> WIN.
    - next_ball_y >= 470 and next_ball_dir[0]=1 -> MISS; miss-tick count=0.
  - Outside ticks, registers hold.
- MISS:
  - Ball registers frozen; count ticks.
  - After MISS_HOLD ticks: lives-1. If the result is 0 -> OVER, else -> IDLE.
  - Bricks and score are kept.
- WIN / OVER:
  - All registers hold.
  - btn_launch -> full game restart (bricks, lives and score get reset values) -> IDLE.
- btn_launch is ignored in PLAY and MISS.
- Simultaneous last-brick clear and miss on the same tick: WIN.
- rst_n asserted in any state, mid-tick included: immediate reset values; the counter restarts at 0.

Optional Feature:
- Macro: BRICK_GAME_SPEEDUP_EN.
- Defined:
  - 4-bit hit counter increments each scoring tick.
  - When it wraps 15->0, ball_vx and ball_vy each +1, capped at VMAX.
  - This override applies after loading next_ball_v*.
  - Hit counter and speeds return to VX0/VY0 on serve from IDLE.
- Undefined: speeds pass through from the datapath unchanged; no hit counter.

Test Plan:
- Reset, then TICK_DIV=4, board_x=100 -> ball_x=140, ball_y=457, lives=3, score=0, bricks[2:0]=3'd1, bricks[362:360]=0, game_state=0.
- Launch pulse, datapath model returns next_ball_y=450 -> game_state=1. Ball registers update only on every 4th cycle; ball_y=450 after the first tick.
- In PLAY, next_bricks clears one slot with collision_trig=1 -> score=1 and sfx_hit high exactly one cycle, aligned to the tick.
- next_ball_y=472, dir=2'b11 -> MISS. After MISS_HOLD ticks lives=2, state IDLE, bricks unchanged. Repeat for 3 misses -> OVER with lives=0; launch then restores lives=3, score=0.
- On one tick: next_bricks all zero and next_ball_y=472 down -> WIN (not MISS). btn_launch -> IDLE with rows 0..5 restored.
- BRICK_GAME_SPEEDUP_EN defined, 16 scoring ticks -> vx=3, vy=3. After 64 more scoring ticks with VMAX=6 -> speeds capped at 6.
- rst_n pulsed low mid-PLAY -> all outputs return to reset values asynchronously.
